inv_share_arbiter: RTL and testbench

INV_SHARE_ARBITER -- requirements
Module: inv_share_arbiter

---
 rtl/inv_share_arbiter.sv | 159 +++++++++++++++
 tb/tb_inv_share_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/inv_share_arbiter.sv
// inv_share_arbiter
//   Time-shares a single device inverter cell among NREQ requesters. An IDLE
//   arbiter picks a round-robin winner, drives the winner's bit onto the
//   device input, waits SETTLE_CYCLES edges, captures the device output and
//   reports it together with the winner index. A sticky error flag records
//   any capture that is not the exact complement of the driven bit.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   req        in   [NREQ]  request levels
//   bit_in     in   [NREQ]  per-requester bit to invert
//   gnt        out  [NREQ]  registered one-hot grant
//   dev_inp    out          registered drive to the device inverter input
//   dev_out    in           device inverter output
//   res_valid  out          one-cycle result strobe
//   res_bit    out          captured dev_out (held until next capture)
//   res_id     out  [IW]    requester served (held until next capture)
//   busy       out          transaction in flight
//   err        out          sticky device-fault flag
//   err_clr    in           clears err (a same-edge fault wins)
module inv_share_arbiter #(
  parameter  int NREQ          = 4,
  parameter  int SETTLE_CYCLES = 2,
  localparam int IW            = $clog2(NREQ),
  localparam int CW            = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] bit_in,
  output logic [NREQ-1:0] gnt,
  output logic            dev_inp,
  input  logic            dev_out,
  output logic            res_valid,
  output logic            res_bit,
  output logic [IW-1:0]   res_id,
  output logic            busy,
  output logic            err,
  input  logic            err_clr
);

  typedef enum logic {IDLE = 1'b0, SETTLE = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              dev_inp_q, dev_inp_d;
  logic [IW-1:0]     id_q, id_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic              res_valid_q, res_valid_d;
  logic              res_bit_q, res_bit_d;
  logic [IW-1:0]     res_id_q, res_id_d;
  logic              err_q, err_d;

  // Round-robin search: first set request at or above ptr, wrapping.
  logic [IW-1:0] win;
  logic          found;
  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  always_comb begin
    win   = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr_q} + (IW+1)'(i);
      if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
      idx = sum[IW-1:0];
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  logic [IW-1:0] ptr_nxt;
  assign ptr_nxt = (id_q == IW'(NREQ-1)) ? '0 : id_q + 1'b1;

  logic err_set;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    dev_inp_d   = dev_inp_q;
    id_d        = id_q;
    ptr_d       = ptr_q;
    res_valid_d = 1'b0;
    res_bit_d   = res_bit_q;
    res_id_d    = res_id_q;
    err_set     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          dev_inp_d  = bit_in[win];
          id_d       = win;
          cnt_d      = CW'(SETTLE_CYCLES-1);
          state_d    = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          res_bit_d   = dev_out;
          res_id_d    = id_q;
          res_valid_d = 1'b1;
          gnt_d       = '0;
          ptr_d       = ptr_nxt;
          state_d     = IDLE;
          // Case inequality so an undriven or x device output counts as a fault.
          err_set     = (dev_out !== ~dev_inp_q);
        end
      end
      default: state_d = IDLE;
    endcase
    // A fault on this edge overrides a simultaneous clear.
    err_d = err_set | (err_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      gnt_q       <= '0;
      dev_inp_q   <= 1'b0;
      id_q        <= '0;
      ptr_q       <= '0;
      res_valid_q <= 1'b0;
      res_bit_q   <= 1'b0;
      res_id_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      dev_inp_q   <= dev_inp_d;
      id_q        <= id_d;
      ptr_q       <= ptr_d;
      res_valid_q <= res_valid_d;
      res_bit_q   <= res_bit_d;
      res_id_q    <= res_id_d;
      err_q       <= err_d;
    end
  end

  assign gnt       = gnt_q;
  assign dev_inp   = dev_inp_q;
  assign res_valid = res_valid_q;
  assign res_bit   = res_bit_q;
  assign res_id    = res_id_q;
  assign busy      = (state_q == SETTLE);
  assign err       = err_q;

endmodule

// File: tb/tb_inv_share_arbiter.sv
module tb_inv_share_arbiter;
  localparam int NREQ = 4;
  localparam int SC   = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] bit_in = '0;
  logic [NREQ-1:0] gnt;
  logic            dev_inp;
  logic            dev_out;
  logic            res_valid;
  logic            res_bit;
  logic [1:0]      res_id;
  logic            busy;
  logic            err;
  logic            err_clr = 1'b0;

  // Device behaviour: 0 good inverter, 1 stuck at 1, 2 stuck at 0.
  int mode = 0;
  assign dev_out = (mode == 0) ? ~dev_inp : (mode == 1);

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  inv_share_arbiter #(.NREQ(NREQ), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .req(req), .bit_in(bit_in), .gnt(gnt),
    .dev_inp(dev_inp), .dev_out(dev_out), .res_valid(res_valid),
    .res_bit(res_bit), .res_id(res_id), .busy(busy), .err(err),
    .err_clr(err_clr)
  );

  // Transaction-level reference: a transaction started at edge n captures
  // at edge n+SC; the pointer moves past the served requester.
  int              edge_n = 0;
  int              m_ptr = 0, m_id = 0, m_cap = 0, m_rid = 0;
  bit              m_busy = 0, m_dev_inp = 0, m_rv = 0, m_rb = 0, m_err = 0;
  logic [NREQ-1:0] m_gnt = '0;

  task automatic step();
    bit dv, eset;
    int w;
    dv   = (mode == 0) ? ~m_dev_inp : (mode == 1);
    eset = 0;
    if (rst) begin
      m_ptr = 0; m_id = 0; m_rid = 0; m_busy = 0; m_dev_inp = 0;
      m_rv = 0; m_rb = 0; m_err = 0; m_gnt = '0;
    end else begin
      m_rv = 0;
      if (m_busy && edge_n == m_cap) begin
        m_rv = 1; m_rb = dv; m_rid = m_id; m_gnt = '0;
        m_ptr = (m_id + 1) % NREQ; m_busy = 0;
        eset = (dv != !m_dev_inp);
      end else if (!m_busy && req != 0) begin
        w = -1;
        for (int k = 0; k < NREQ; k++)
          if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
        m_id = w; m_busy = 1; m_cap = edge_n + SC;
        m_gnt = '0; m_gnt[w] = 1'b1; m_dev_inp = bit_in[w];
      end
      m_err = eset || (m_err && !err_clr);
    end
    edge_n++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1; step(); step();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
    total++; if (dev_inp !== 1'b0 || res_valid !== 1'b0 || res_bit !== 1'b0) begin bad++;
      $display("FAIL reset_outs got dev_inp=%b rv=%b rb=%b want 0 0 0", dev_inp, res_valid, res_bit); end
    total++; if (res_id !== 2'd0 || err !== 1'b0 || busy !== 1'b0) begin bad++;
      $display("FAIL reset_state got id=%0d err=%b busy=%b want 0 0 0", res_id, err, busy); end
    rst = 0;
  endtask

  task automatic test_single();
    mode = 0; req = 4'b0001; bit_in = 4'b0001;
    step();
    req = 4'b0000;
    total++; if (gnt !== 4'b0001 || dev_inp !== 1'b1 || busy !== 1'b1) begin bad++;
      $display("FAIL single_grant got gnt=%b dev_inp=%b busy=%b want 0001 1 1", gnt, dev_inp, busy); end
    step();
    total++; if (res_valid !== 1'b0 || gnt !== 4'b0001) begin bad++;
      $display("FAIL single_hold got rv=%b gnt=%b want 0 0001", res_valid, gnt); end
    step();
    total++; if (res_valid !== 1'b1 || res_bit !== 1'b0 || res_id !== 2'd0 || err !== 1'b0 || gnt !== 4'b0000) begin bad++;
      $display("FAIL single_capture got rv=%b rb=%b id=%0d err=%b gnt=%b want 1 0 0 0 0000", res_valid, res_bit, res_id, err, gnt); end
    step();
    total++; if (res_valid !== 1'b0 || res_bit !== 1'b0 || dev_inp !== 1'b1 || busy !== 1'b0) begin bad++;
      $display("FAIL single_after got rv=%b rb=%b dev_inp=%b busy=%b want 0 0 1 0", res_valid, res_bit, dev_inp, busy); end
  endtask

  task automatic test_round_robin();
    rst = 1; step(); rst = 0;
    mode = 0; req = 4'b1111; bit_in = 4'b1010;
    step();
    for (int t = 0; t < 5; t++) begin
      step();
      total++; if ($onehot0(gnt) !== 1'b1 || res_valid !== 1'b0) begin bad++;
        $display("FAIL rr_mid t=%0d got gnt=%b rv=%b", t, gnt, res_valid); end
      step();
      total++; if (res_valid !== 1'b1 || res_id !== 2'(t % NREQ) || res_bit !== ~bit_in[t % NREQ]) begin bad++;
        $display("FAIL rr_capture t=%0d got rv=%b id=%0d rb=%b want 1 %0d %b", t, res_valid, res_id, res_bit, t % NREQ, ~bit_in[t % NREQ]); end
      if (t == 4) req = 4'b0000;
      step();
      total++; if ($onehot0(gnt) !== 1'b1 || res_valid !== 1'b0) begin bad++;
        $display("FAIL rr_regrant t=%0d got gnt=%b rv=%b", t, gnt, res_valid); end
    end
  endtask

  task automatic test_fault();
    rst = 1; step(); rst = 0;
    mode = 1; req = 4'b0001; bit_in = 4'b0001;
    step(); req = 4'b0000; step(); step();
    total++; if (res_valid !== 1'b1 || res_bit !== 1'b1 || err !== 1'b1) begin bad++;
      $display("FAIL fault_capture got rv=%b rb=%b err=%b want 1 1 1", res_valid, res_bit, err); end
    step(); step();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL fault_sticky got err=%b want 1", err); end
    err_clr = 1; step(); err_clr = 0;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL fault_clear got err=%b want 0", err); end
    mode = 0;
  endtask

  task automatic test_collision();
    rst = 1; step(); rst = 0;
    mode = 1; req = 4'b0001; bit_in = 4'b0001;
    step(); req = 4'b0000; step();
    err_clr = 1; step(); err_clr = 0;
    total++; if (res_valid !== 1'b1 || err !== 1'b1) begin bad++;
      $display("FAIL collision got rv=%b err=%b want 1 1", res_valid, err); end
    mode = 0;
  endtask

  task automatic test_reset_mid();
    bit seen;
    rst = 1; step(); rst = 0;
    mode = 0; req = 4'b0100; bit_in = 4'b0100;
    step();
    total++; if (gnt !== 4'b0100 || dev_inp !== 1'b1) begin bad++;
      $display("FAIL rmid_grant got gnt=%b dev_inp=%b want 0100 1", gnt, dev_inp); end
    rst = 1; req = 4'b0000; step(); rst = 0;
    total++; if (gnt !== 4'b0000 || busy !== 1'b0 || dev_inp !== 1'b0) begin bad++;
      $display("FAIL rmid_abort got gnt=%b busy=%b dev_inp=%b want 0000 0 0", gnt, busy, dev_inp); end
    seen = 0;
    for (int i = 0; i < 3; i++) begin step(); if (res_valid) seen = 1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rmid_no_result got seen=%b want 0", seen); end
    req = 4'b1111; step(); req = 4'b0000;
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL rmid_ptr got gnt=%b want 0001", gnt); end
    step(); step();
  endtask

  task automatic test_dropped();
    rst = 1; step(); rst = 0;
    mode = 0; req = 4'b0100; bit_in = 4'b0000;
    step();
    req = 4'b0000; bit_in = 4'b1111;
    step();
    total++; if (dev_inp !== 1'b0 || gnt !== 4'b0100) begin bad++;
      $display("FAIL drop_hold got dev_inp=%b gnt=%b want 0 0100", dev_inp, gnt); end
    step();
    total++; if (res_valid !== 1'b1 || res_id !== 2'd2 || res_bit !== 1'b1) begin bad++;
      $display("FAIL drop_capture got rv=%b id=%0d rb=%b want 1 2 1", res_valid, res_id, res_bit); end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    rst = 1; step(); rst = 0;
    for (int i = 0; i < 400; i++) begin
      req     = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      bit_in  = 4'($urandom);
      err_clr = ($urandom_range(0, 7) == 0);
      rst     = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 19) == 0) mode = $urandom_range(0, 2);
      step();
      total++;
      if (gnt !== m_gnt || dev_inp !== m_dev_inp || res_valid !== m_rv || busy !== m_busy ||
          res_bit !== m_rb || res_id !== 2'(m_rid) || err !== m_err) begin
        bad++; errs++;
        if (errs < 10)
          $display("FAIL random i=%0d got gnt=%b inp=%b rv=%b busy=%b rb=%b id=%0d err=%b want %b %b %b %b %b %0d %b",
                   i, gnt, dev_inp, res_valid, busy, res_bit, res_id, err,
                   m_gnt, m_dev_inp, m_rv, m_busy, m_rb, m_rid, m_err);
      end
    end
    rst = 0; err_clr = 0; req = '0; mode = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_fault();
    test_collision();
    test_reset_mid();
    test_dropped();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
